ticket_dispense_arbiter: RTL
============================

// Module: ticket_dispense_arbiter
// PURPOSE
//  Shares one ticket printer and one coin-return hopper among N_BOOTHS fare booths.
//  Each booth raises a request once its fare is paid; the arbiter picks one booth per
//  transaction by round-robin and then runs that booth's sequence: print, return change,
//  acknowledge. It sits between the booth FSMs and the printer/hopper drivers.
// PARAMETERS
//  N_BOOTHS      4  number of requesting booths (2..8)
//  PRINT_CYCLES  3  cycles print_en is held high per ticket (>=1)
//  CHANGE_W      2  width of each booth's change count, in nickels
// PORTS
//  clock        in   1                  single system clock, rising edge
//  reset        in   1                  synchronous, active-high
//  req          in   N_BOOTHS           booth i has paid and wants a ticket; level, held until done[i]
//  change_cnt   in   N_BOOTHS*CHANGE_W  nickels owed to booth i, in bits [i*CHANGE_W +: CHANGE_W]
//  route_number in   N_BOOTHS*4         route for booth i, in bits [i*4 +: 4]
//  grant        out  N_BOOTHS           one-hot; booth currently being served
//  done         out  N_BOOTHS           one-cycle pulse to the served booth when its transaction ends
//  print_en     out  1                  printer strobe
//  print_route  out  4                  route to print; valid while print_en is high
//  nickel_out   out  1                  hopper strobe; one pulse releases one nickel
//  busy         out  1                  high in every state except IDLE
// BEHAVIOUR
//  - Reset (checked at the clock edge) drives all outputs to 0, state to IDLE and rr_ptr to 0.
//    An in-flight transaction is abandoned and no done pulse is issued.
//  - States: IDLE -> PRINT -> CHANGE -> DONE -> IDLE. CHANGE is skipped when the latched count is 0.
//  - IDLE: if req is nonzero at edge k, the winner is the first booth with req set, searching
//    from rr_ptr upward and wrapping. At the same edge the FSM latches the winner's change_cnt
//    and route_number, registers grant, and enters PRINT.
//  - PRINT: print_en=1 and print_route=latched route for exactly PRINT_CYCLES cycles.
//  - CHANGE: for a latched count c, nickel_out alternates 1,0 for 2*c cycles, high first.
//    nickel_out is never high in two consecutive cycles.
//  - DONE: lasts one cycle. done[winner]=1 in that cycle and grant stays high.
//    On the next edge grant clears, rr_ptr becomes (winner+1) mod N_BOOTHS, and the state
//    returns to IDLE.
//  - Latency: with req sampled at edge k, print_en is high in cycles k..k+P-1 (P=PRINT_CYCLES)
//    and done is high in cycle k+P+2c.
//  - Rearbitration happens only in IDLE. There is therefore at least one idle cycle between
//    transactions, and grant is never asserted in IDLE.
//  - req, change_cnt and route_number are ignored outside IDLE. Dropping req mid-transaction
//    does not abort it. A requester still asserting req after done competes again at lowest
//    priority.
//  - Simultaneous requests: exactly one grant. No starvation; any asserted req is served
//    within N_BOOTHS transactions.
//  - Outputs are registered. print_en, nickel_out and done are mutually exclusive in any cycle.
// STRUCTURE
//  - Shared package asts_pkg:
//    - state enum: IDLE, PRINT, CHANGE, DONE
//    - ROUTE_W = 4
//    - defaults for CHANGE_W and PRINT_CYCLES
//  - Sub-module rr_arbiter (parameter N):
//    - combinational one-hot select from req and rr_ptr
//    - owns the rr_ptr register and its update on an advance strobe
//  - The top level holds the FSM, the print/change down-counters and the latch registers.
// TESTING
//  - Reset: assert reset for 2 cycles with req=4'b1111 -> all outputs 0 and busy=0
//    throughout; first grant goes to booth 0.
//  - Single booth: req=4'b0010, route_number[7:4]=4'd1, cnt[3:2]=2'd1
//    -> grant=4'b0010; print_en high 3 cycles with print_route=1; one nickel_out pulse;
//       done[1] at k+5.
//  - Zero change: booth 2 with cnt=0 -> no nickel_out; done[2] in cycle k+3.
//  - Contention: hold req=4'b1011 through repeated transactions -> served order 0,1,3,0,1,3.
//    grant is always one-hot with an idle cycle between transactions.
//  - Mid-operation: drop req during PRINT -> transaction completes with done pulse. Assert
//    reset during CHANGE -> nickel_out=0 next cycle, no done, state IDLE.
//  - Max change: cnt=2'd3 -> exactly 3 nickel_out pulses with pattern 1,0,1,0,1,0, then done.

Source files
------------

// File: rtl/asts_pkg.sv
// Shared types and defaults for the ticket dispense arbiter.
package asts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRINT  = 2'd1,
    CHANGE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int ROUTE_W          = 4;
  localparam int DEF_CHANGE_W     = 2;
  localparam int DEF_PRINT_CYCLES = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector; owns the priority pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,   // pointer moves past adv_sel this edge
  input  logic [N-1:0] adv_sel,
  output logic [N-1:0] sel
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // first requester at or after ptr_q, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      idx = PW'((int'(ptr_q) + o) % N);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // served booth drops to lowest priority
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (adv_sel[i]) ptr_d = PW'((i + 1) % N);
      end
    end
  end

  // pointer register
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ticket_dispense_arbiter.sv
// Shares one printer and one coin hopper among N_BOOTHS booths:
// round-robin pick in IDLE, then print, return change, acknowledge.
module ticket_dispense_arbiter
  import asts_pkg::*;
#(
  parameter int N_BOOTHS     = 4,
  parameter int PRINT_CYCLES = DEF_PRINT_CYCLES,
  parameter int CHANGE_W     = DEF_CHANGE_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_BOOTHS-1:0]          req,
  input  logic [N_BOOTHS*CHANGE_W-1:0] change_cnt,
  input  logic [N_BOOTHS*ROUTE_W-1:0]  route_number,
  output logic [N_BOOTHS-1:0]          grant,
  output logic [N_BOOTHS-1:0]          done,
  output logic                         print_en,
  output logic [ROUTE_W-1:0]           print_route,
  output logic                         nickel_out,
  output logic                         busy
);

  // one counter serves both the print phase and the 2*c change phase
  localparam int CHG_MAX = 2 * ((1 << CHANGE_W) - 1);
  localparam int CNT_MAX = (PRINT_CYCLES > CHG_MAX) ? PRINT_CYCLES : CHG_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CHANGE_W-1:0]   chg_q, chg_d;
  logic [ROUTE_W-1:0]    route_q, route_d;
  logic [N_BOOTHS-1:0]   win_q, win_d;

  logic [N_BOOTHS-1:0]   grant_q, grant_d;
  logic [N_BOOTHS-1:0]   done_q, done_d;
  logic                  print_en_q, print_en_d;
  logic [ROUTE_W-1:0]    print_route_q, print_route_d;
  logic                  nickel_q, nickel_d;
  logic                  busy_q, busy_d;

  logic [N_BOOTHS-1:0]   sel;

  rr_arbiter #(.N(N_BOOTHS)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (state_q == DONE),
    .adv_sel (win_q),
    .sel     (sel)
  );

  // transaction sequencing and input latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg_d   = chg_q;
    route_d = route_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = PRINT;
          cnt_d   = CNT_W'(PRINT_CYCLES - 1);
          win_d   = sel;
          for (int i = 0; i < N_BOOTHS; i++) begin
            if (sel[i]) begin
              chg_d   = change_cnt[i*CHANGE_W +: CHANGE_W];
              route_d = route_number[i*ROUTE_W +: ROUTE_W];
            end
          end
        end
      end
      PRINT: begin
        if (cnt_q == '0) begin
          if (chg_q != '0) begin
            state_d = CHANGE;
            // odd start value makes the first change cycle a high one
            cnt_d   = CNT_W'((int'(chg_q) << 1) - 1);
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHANGE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        win_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from next state so they land registered
  always_comb begin
    busy_d        = (state_d != IDLE);
    grant_d       = busy_d ? win_d : '0;
    done_d        = (state_d == DONE) ? win_d : '0;
    print_en_d    = (state_d == PRINT);
    print_route_d = print_en_d ? route_d : '0;
    nickel_d      = (state_d == CHANGE) && cnt_d[0];
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      chg_q         <= '0;
      route_q       <= '0;
      win_q         <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      print_en_q    <= 1'b0;
      print_route_q <= '0;
      nickel_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chg_q         <= chg_d;
      route_q       <= route_d;
      win_q         <= win_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      print_en_q    <= print_en_d;
      print_route_q <= print_route_d;
      nickel_q      <= nickel_d;
      busy_q        <= busy_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign print_en    = print_en_q;
  assign print_route = print_route_q;
  assign nickel_out  = nickel_q;
  assign busy        = busy_q;

endmodule
